// File: rtl/wb_stage_resp.sv
// Writeback stage with its own MEM->WB register and a decoupled load response.
// Early responses queue in an in-order FIFO; responses owed to flushed loads are dropped.
module wb_stage_resp #(
  parameter int RESP_DEPTH = 2,
  parameter int OUTST_MAX  = 4,
  parameter int RF_AW      = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ms_valid,
  output logic             ws_allowin,
  input  logic [31:0]      pc,
  input  logic [31:0]      result,
  input  logic [4:0]       mem_op,
  input  logic             res_from_mem,
  input  logic             gr_we,
  input  logic [RF_AW-1:0] dest,
  input  logic             has_exception,
  input  logic [5:0]       ecode,
  input  logic [8:0]       esubcode,
  input  logic [31:0]      maddr,
  input  logic             ertn,
  input  logic             rdcntid,
  input  logic [31:0]      csr_tid,
  input  logic             req_fire,
  input  logic             data_ok,
  input  logic [31:0]      rdata,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_we,
  output logic [RF_AW-1:0] debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata,
  output logic             exception_submit,
  output logic [5:0]       ecode_submit,
  output logic [8:0]       esubcode_submit,
  output logic [31:0]      exception_pc_submit,
  output logic [31:0]      exception_maddr_submit,
  output logic             ertn_submit,
  output logic             this_flush,
  output logic             fwd_valid,
  output logic [RF_AW-1:0] fwd_dest,
  output logic [31:0]      fwd_data,
  output logic             fwd_block
);

  localparam int CW = $clog2(OUTST_MAX + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int FW = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      result;
    logic [4:0]       mem_op;
    logic             res_from_mem;
    logic             gr_we;
    logic [RF_AW-1:0] dest;
    logic             has_exception;
    logic [5:0]       ecode;
    logic [8:0]       esubcode;
    logic [31:0]      maddr;
    logic             ertn;
    logic             rdcntid;
  } ms_ws_t;

  ms_ws_t          ms_pl;
  ms_ws_t          pl;
  logic            ws_valid;
  logic [31:0]     mem [RESP_DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [FW-1:0]   fcnt;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   outst_nxt;
  logic [CW-1:0]   drop_cnt;
  logic            load;
  logic            need_data;
  logic            fifo_empty;
  logic            fifo_full;
  logic            drop_active;
  logic            ready_go;
  logic            commit;
  logic            push;
  logic            pop;
  logic [31:0]     ld_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ext;
  logic [31:0]     wb_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign ms_pl = '{pc: pc, result: result, mem_op: mem_op,
                   res_from_mem: res_from_mem, gr_we: gr_we, dest: dest,
                   has_exception: has_exception, ecode: ecode,
                   esubcode: esubcode, maddr: maddr, ertn: ertn,
                   rdcntid: rdcntid};

  assign load        = pl.res_from_mem & ~pl.has_exception;
  assign need_data   = ws_valid & load;
  assign fifo_empty  = (fcnt == '0);
  assign fifo_full   = (fcnt == FW'(RESP_DEPTH));
  assign drop_active = (drop_cnt != '0);
  assign ready_go    = ~need_data | ~fifo_empty | (data_ok & ~drop_active);
  assign commit      = ws_valid & ready_go;
  assign this_flush  = commit & pl.has_exception;
  assign ws_allowin  = ~ws_valid | ready_go;
  assign push        = data_ok & ~drop_active & ~(need_data & fifo_empty);
  assign pop         = commit & load & ~fifo_empty;
  assign ld_data     = fifo_empty ? rdata : mem[rptr];
  assign ld_byte     = ld_data[{pl.result[1:0], 3'b000} +: 8];
  assign ld_half     = pl.result[1] ? ld_data[31:16] : ld_data[15:0];
  assign outst_nxt   = outst + CW'(req_fire) - CW'(data_ok);

  // Extend the selected load data according to the one-hot mem_op
  always_comb begin
    ext = ld_data;
    unique case (1'b1)
      pl.mem_op[0]: ext = {{24{ld_byte[7]}}, ld_byte};
      pl.mem_op[1]: ext = {{16{ld_half[15]}}, ld_half};
      pl.mem_op[2]: ext = ld_data;
      pl.mem_op[3]: ext = {24'h0, ld_byte};
      pl.mem_op[4]: ext = {16'h0, ld_half};
      default:      ext = ld_data;
    endcase
  end

  assign wb_data = pl.rdcntid ? csr_tid : load ? ext : pl.result;

  // MEM->WB register; a flushing commit refuses the incoming instruction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
      pl       <= '0;
    end else if (ws_allowin) begin
      ws_valid <= ms_valid & ~this_flush;
      if (ms_valid & ~this_flush) pl <= ms_pl;
    end
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
    end else if (this_flush) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      if (push & ~pop)      fcnt <= fcnt + FW'(1);
      else if (pop & ~push) fcnt <= fcnt - FW'(1);
    end
  end

  // Response FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= rdata;
  end

  // Outstanding requests and responses owed to cancelled loads
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outst    <= '0;
      drop_cnt <= '0;
    end else begin
      outst <= outst_nxt;
      if (this_flush)                drop_cnt <= outst_nxt;
      else if (drop_active & data_ok) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  assign rf_we                  = commit & pl.gr_we & ~pl.has_exception;
  assign rf_waddr               = pl.dest;
  assign rf_wdata               = wb_data;
  assign debug_wb_pc            = pl.pc;
  assign debug_wb_rf_we         = {4{rf_we}};
  assign debug_wb_rf_wnum       = pl.dest;
  assign debug_wb_rf_wdata      = wb_data;
  assign exception_submit       = this_flush;
  assign ecode_submit           = pl.ecode;
  assign esubcode_submit        = pl.esubcode;
  assign exception_pc_submit    = pl.pc;
  assign exception_maddr_submit = pl.maddr;
  assign ertn_submit            = commit & pl.ertn;
  assign fwd_valid              = ws_valid & pl.gr_we & ~pl.has_exception;
  assign fwd_dest               = pl.dest;
  assign fwd_data               = wb_data;
  assign fwd_block              = need_data & ~ready_go;

  a_no_push_full: assert property (
    @(posedge clk) disable iff (!resetn) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_wb_stage_resp.sv
// Scoreboard bench for wb_stage_resp: expected writes queued at drive time,
// popped and compared when the stage commits.
module tb_wb_stage_resp;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ms_valid = 1'b0;
  logic        ws_allowin;
  logic [31:0] pc = '0;
  logic [31:0] result = '0;
  logic [4:0]  mem_op = '0;
  logic        res_from_mem = 1'b0;
  logic        gr_we = 1'b0;
  logic [4:0]  dest = '0;
  logic        has_exception = 1'b0;
  logic [5:0]  ecode = '0;
  logic [8:0]  esubcode = '0;
  logic [31:0] maddr = '0;
  logic        ertn = 1'b0;
  logic        rdcntid = 1'b0;
  logic [31:0] csr_tid = '0;
  logic        req_fire = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        exception_submit;
  logic [5:0]  ecode_submit;
  logic [8:0]  esubcode_submit;
  logic [31:0] exception_pc_submit;
  logic [31:0] exception_maddr_submit;
  logic        ertn_submit;
  logic        this_flush;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        fwd_block;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_assert = 0;
  int   n_fail = 0;

  wb_stage_resp dut (
    .clk(clk), .resetn(resetn), .ms_valid(ms_valid),
    .ws_allowin(ws_allowin), .pc(pc), .result(result),
    .mem_op(mem_op), .res_from_mem(res_from_mem), .gr_we(gr_we),
    .dest(dest), .has_exception(has_exception), .ecode(ecode),
    .esubcode(esubcode), .maddr(maddr), .ertn(ertn),
    .rdcntid(rdcntid), .csr_tid(csr_tid), .req_fire(req_fire),
    .data_ok(data_ok), .rdata(rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .exception_submit(exception_submit), .ecode_submit(ecode_submit),
    .esubcode_submit(esubcode_submit),
    .exception_pc_submit(exception_pc_submit),
    .exception_maddr_submit(exception_maddr_submit),
    .ertn_submit(ertn_submit), .this_flush(this_flush),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .fwd_block(fwd_block)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] r,
                       input logic [4:0] op, input logic rfm,
                       input logic we, input logic [4:0] d,
                       input logic exc, input logic [5:0] ec,
                       input logic rdc, input logic [31:0] expd,
                       input logic expw);
    ms_valid = 1'b1; pc = p; result = r; mem_op = op;
    res_from_mem = rfm; gr_we = we; dest = d; has_exception = exc;
    ecode = ec; esubcode = 9'h3; maddr = r ^ 32'h5; rdcntid = rdc;
    if (expw) q.push_back('{a: d, d: expd});
  endtask

  task automatic idle_ms;
    ms_valid = 1'b0; pc = '0; result = '0; mem_op = '0;
    res_from_mem = 1'b0; gr_we = 1'b0; dest = '0;
    has_exception = 1'b0; ecode = '0; esubcode = '0; maddr = '0;
    rdcntid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_assert++;
    if (ws_allowin !== 1'b1) begin
      n_fail++; $display("FAIL rst_allowin got %0b want 1", ws_allowin);
    end
    n_assert++;
    if ({rf_we, exception_submit, this_flush, ertn_submit} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_commit got %0b%0b%0b%0b want 0000", rf_we,
               exception_submit, this_flush, ertn_submit);
    end
    n_assert++;
    if ({fwd_valid, fwd_block, fwd_data, debug_wb_pc} !== 66'b0) begin
      n_fail++;
      $display("FAIL rst_fwd got v=%0b b=%0b d=%h pc=%h want 0", fwd_valid,
               fwd_block, fwd_data, debug_wb_pc);
    end
    resetn = 1'b1;
    tick;
  endtask

  task automatic test_nonload;
    drive(32'h1c00_0000, 32'h1234, 5'b0, 1'b0, 1'b1, 5'd5, 1'b0, 6'h0,
          1'b0, 32'h1234, 1'b1);
    @(negedge clk);
    n_assert++;
    if (ws_allowin !== 1'b1) begin
      n_fail++; $display("FAIL nl_allowin0 got %0b want 1", ws_allowin);
    end
    tick;
    idle_ms;
    @(negedge clk);
    n_assert++;
    if (rf_we !== 1'b1 || q.size() == 0) begin
      n_fail++; $display("FAIL nl_commit rf_we got %0b want 1", rf_we);
    end else begin
      e = q.pop_front();
      if (rf_waddr !== e.a || rf_wdata !== e.d) begin
        n_fail++;
        $display("FAIL nl_data got %0d/%h want %0d/%h", rf_waddr, rf_wdata,
                 e.a, e.d);
      end
    end
    n_assert++;
    if ({ws_allowin, debug_wb_rf_we, debug_wb_pc} !== {1'b1, 4'hf, 32'h1c00_0000}) begin
      n_fail++;
      $display("FAIL nl_dbg got a=%0b we=%h pc=%h want 1/f/1c000000",
               ws_allowin, debug_wb_rf_we, debug_wb_pc);
    end
    tick;
  endtask

  task automatic test_late(input logic [4:0] op, input logic [31:0] expd,
                           input logic [4:0] d);
    req_fire = 1'b1;
    tick;
    req_fire = 1'b0;
    drive(32'h1c00_0010, 32'h0000_0102, op, 1'b1, 1'b1, d, 1'b0, 6'h0,
          1'b0, expd, 1'b1);
    tick;
    idle_ms;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_assert++;
      if ({fwd_block, ws_allowin, rf_we} !== 3'b100) begin
        n_fail++;
        $display("FAIL late_stall%0d got blk=%0b alw=%0b we=%0b want 1/0/0",
                 i, fwd_block, ws_allowin, rf_we);
      end
      tick;
    end
    data_ok = 1'b1;
    rdata = 32'h0080_0000;
    @(negedge clk);
    n_assert++;
    if (rf_we !== 1'b1 || q.size() == 0) begin
      n_fail++; $display("FAIL late_commit rf_we got %0b want 1", rf_we);
    end else begin
      e = q.pop_front();
      if (rf_waddr !== e.a || rf_wdata !== e.d || fwd_block !== 1'b0) begin
        n_fail++;
        $display("FAIL late_data got %0d/%h blk=%0b want %0d/%h blk=0",
                 rf_waddr, rf_wdata, fwd_block, e.a, e.d);
      end
    end
    tick;
    data_ok = 1'b0;
  endtask

  task automatic test_ext;
    logic [4:0]  ops [6];
    logic [1:0]  offs [6];
    logic [31:0] exps [6];
    ops  = '{5'b00001, 5'b01000, 5'b00010, 5'b10000, 5'b00100, 5'b00001};
    offs = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3};
    exps = '{32'hFFFF_FFA1, 32'h0000_00C3, 32'hFFFF_8765, 32'h0000_C3A1,
             32'h8765_C3A1, 32'hFFFF_FF87};
    for (int i = 0; i < 6; i++) begin
      req_fire = 1'b1;
      tick;
      req_fire = 1'b0;
      data_ok = 1'b1;
      rdata = 32'h8765_C3A1;
      tick;
      data_ok = 1'b0;
      drive(32'h1c00_0200, {30'h40, offs[i]}, ops[i], 1'b1, 1'b1, 5'd13,
            1'b0, 6'h0, 1'b0, exps[i], 1'b1);
      tick;
      idle_ms;
      @(negedge clk);
      n_assert++;
      if (rf_we !== 1'b1 || q.size() == 0) begin
        n_fail++; $display("FAIL ext%0d_commit rf_we got %0b want 1", i, rf_we);
      end else begin
        e = q.pop_front();
        if (rf_wdata !== e.d) begin
          n_fail++;
          $display("FAIL ext%0d_data got %h want %h", i, rf_wdata, e.d);
        end
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    req_fire = 1'b1;
    tick;
    tick;
    req_fire = 1'b0;
    data_ok = 1'b1;
    rdata = 32'hAAAA_AAAA;
    tick;
    rdata = 32'hBBBB_BBBB;
    tick;
    data_ok = 1'b0;
    @(negedge clk);
    n_assert++;
    if (dut.fcnt !== 2'd2) begin
      n_fail++; $display("FAIL b2b_count got %0d want 2", dut.fcnt);
    end
    drive(32'h1c00_0020, 32'h100, 5'b00100, 1'b1, 1'b1, 5'd8, 1'b0, 6'h0,
          1'b0, 32'hAAAA_AAAA, 1'b1);
    tick;
    drive(32'h1c00_0024, 32'h104, 5'b00100, 1'b1, 1'b1, 5'd9, 1'b0, 6'h0,
          1'b0, 32'hBBBB_BBBB, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_assert++;
      if (rf_we !== 1'b1 || ws_allowin !== 1'b1 || q.size() == 0) begin
        n_fail++;
        $display("FAIL b2b%0d_commit we=%0b alw=%0b want 1/1", i, rf_we,
                 ws_allowin);
      end else begin
        e = q.pop_front();
        if (rf_waddr !== e.a || rf_wdata !== e.d) begin
          n_fail++;
          $display("FAIL b2b%0d_data got %0d/%h want %0d/%h", i, rf_waddr,
                   rf_wdata, e.a, e.d);
        end
      end
      tick;
      idle_ms;
    end
  endtask

  task automatic test_flush_drop;
    req_fire = 1'b1;
    tick;
    tick;
    req_fire = 1'b0;
    drive(32'h1c00_0100, 32'h77, 5'b0, 1'b0, 1'b1, 5'd9, 1'b1, 6'h8,
          1'b0, 32'h0, 1'b0);
    tick;
    drive(32'h1c00_0104, 32'h99, 5'b0, 1'b0, 1'b1, 5'd10, 1'b0, 6'h0,
          1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_assert++;
    if ({exception_submit, this_flush, rf_we} !== 3'b110) begin
      n_fail++;
      $display("FAIL fl_submit got exc=%0b fl=%0b we=%0b want 1/1/0",
               exception_submit, this_flush, rf_we);
    end
    n_assert++;
    if ({ecode_submit, exception_pc_submit, exception_maddr_submit} !==
        {6'h8, 32'h1c00_0100, 32'h72}) begin
      n_fail++;
      $display("FAIL fl_fields got %h/%h/%h want 08/1c000100/00000072",
               ecode_submit, exception_pc_submit, exception_maddr_submit);
    end
    tick;
    idle_ms;
    @(negedge clk);
    n_assert++;
    if ({rf_we, fwd_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL fl_ignore got we=%0b fv=%0b want 0/0", rf_we, fwd_valid);
    end
    req_fire = 1'b1;
    tick;
    req_fire = 1'b0;
    data_ok = 1'b1;
    rdata = 32'h1111_1111;
    tick;
    rdata = 32'h2222_2222;
    tick;
    rdata = 32'h3333_3333;
    tick;
    data_ok = 1'b0;
    drive(32'h1c00_0108, 32'h200, 5'b00100, 1'b1, 1'b1, 5'd11, 1'b0, 6'h0,
          1'b0, 32'h3333_3333, 1'b1);
    tick;
    idle_ms;
    @(negedge clk);
    n_assert++;
    if (rf_we !== 1'b1 || q.size() == 0) begin
      n_fail++; $display("FAIL fl_load rf_we got %0b want 1", rf_we);
    end else begin
      e = q.pop_front();
      if (rf_waddr !== e.a || rf_wdata !== e.d) begin
        n_fail++;
        $display("FAIL fl_data got %0d/%h want %0d/%h", rf_waddr, rf_wdata,
                 e.a, e.d);
      end
    end
    tick;
  endtask

  task automatic test_rdcntid;
    csr_tid = 32'h7;
    drive(32'h1c00_0300, 32'hDEAD_BEEF, 5'b0, 1'b0, 1'b1, 5'd12, 1'b0,
          6'h0, 1'b1, 32'h7, 1'b1);
    tick;
    idle_ms;
    @(negedge clk);
    n_assert++;
    if (rf_we !== 1'b1 || q.size() == 0) begin
      n_fail++; $display("FAIL tid_commit rf_we got %0b want 1", rf_we);
    end else begin
      e = q.pop_front();
      if (rf_waddr !== e.a || rf_wdata !== e.d) begin
        n_fail++;
        $display("FAIL tid_data got %0d/%h want %0d/%h", rf_waddr, rf_wdata,
                 e.a, e.d);
      end
    end
    n_assert++;
    if ({fwd_valid, fwd_dest, fwd_data} !== {1'b1, 5'd12, 32'h7}) begin
      n_fail++;
      $display("FAIL tid_fwd got %0b/%0d/%h want 1/12/7", fwd_valid,
               fwd_dest, fwd_data);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    req_fire = 1'b1;
    tick;
    req_fire = 1'b0;
    data_ok = 1'b1;
    rdata = 32'hCAFE_F00D;
    tick;
    data_ok = 1'b0;
    drive(32'h1c00_0400, 32'h55, 5'b0, 1'b0, 1'b1, 5'd3, 1'b0, 6'h0,
          1'b0, 32'h55, 1'b1);
    tick;
    idle_ms;
    #1;
    resetn = 1'b0;
    q.delete();
    #1;
    n_assert++;
    if ({rf_we, debug_wb_rf_we, rf_wdata, debug_wb_pc, fwd_valid,
         exception_submit} !== 70'b0) begin
      n_fail++;
      $display("FAIL rm_outputs got we=%0b d=%h pc=%h fv=%0b want 0", rf_we,
               rf_wdata, debug_wb_pc, fwd_valid);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick;
    @(negedge clk);
    n_assert++;
    if (ws_allowin !== 1'b1) begin
      n_fail++; $display("FAIL rm_allowin got %0b want 1", ws_allowin);
    end
    req_fire = 1'b1;
    tick;
    req_fire = 1'b0;
    drive(32'h1c00_0404, 32'h300, 5'b00100, 1'b1, 1'b1, 5'd4, 1'b0, 6'h0,
          1'b0, 32'h1234_5678, 1'b1);
    tick;
    idle_ms;
    @(negedge clk);
    n_assert++;
    if ({ws_allowin, fwd_block} !== 2'b01) begin
      n_fail++;
      $display("FAIL rm_empty got alw=%0b blk=%0b want 0/1", ws_allowin,
               fwd_block);
    end
    tick;
    data_ok = 1'b1;
    rdata = 32'h1234_5678;
    @(negedge clk);
    n_assert++;
    if (rf_we !== 1'b1 || q.size() == 0) begin
      n_fail++; $display("FAIL rm_commit rf_we got %0b want 1", rf_we);
    end else begin
      e = q.pop_front();
      if (rf_waddr !== e.a || rf_wdata !== e.d) begin
        n_fail++;
        $display("FAIL rm_data got %0d/%h want %0d/%h", rf_waddr, rf_wdata,
                 e.a, e.d);
      end
    end
    tick;
    data_ok = 1'b0;
  endtask

  initial begin
    test_reset;
    test_nonload;
    test_late(5'b00001, 32'hFFFF_FF80, 5'd7);
    test_late(5'b01000, 32'h0000_0080, 5'd6);
    test_ext;
    test_back_to_back;
    test_flush_drop;
    test_rdcntid;
    test_reset_mid;
    n_assert++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover got %0d want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
